jump_controller: RTL and testbench
==================================

JUMP_CONTROLLER -- requirements
Module: jump_controller

Interface
REQ-001 The block SHALL have parameter GROUND_Y, default 200, meaning dino top-edge Y on ground (10-bit).
REQ-002 The block SHALL have parameter JUMP_HEIGHT, default 64, meaning apex height above ground (8-bit, nonzero).
REQ-003 The block SHALL have parameter RISE_STEP, default 8, meaning height gained per tick in ASCEND (nonzero).
REQ-004 The block SHALL have parameter FALL_STEP, default 8, meaning height lost per tick in DESCEND (nonzero).
REQ-005 The block SHALL have parameter HANG_TICKS, default 4, meaning ticks spent at apex (1..255).
REQ-006 The block SHALL have port clk, input, 1, meaning system clock.
REQ-007 The block SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-008 The block SHALL have port tick, input, 1, meaning one-clk game-frame strobe.
REQ-009 The block SHALL have port jump_pressed, input, 1, meaning debounced jump level.
REQ-010 The block SHALL have port game_active, input, 1, meaning play enabled; low freezes dino on ground.
REQ-011 The block SHALL have port dino_y, output, 10, meaning registered GROUND_Y minus current height.
REQ-012 The block SHALL have port airborne, output, 1, meaning state is not IDLE.
REQ-013 The block SHALL have port jump_start, output, 1, meaning one-clk pulse on IDLE->ASCEND.
REQ-014 The block SHALL have port state, output, 2, meaning IDLE=0, ASCEND=1, HANG=2, DESCEND=3.

Function
REQ-015 The block SHALL register jump_pressed every clk and detect rising edge as current high and previous low.
REQ-016 The block SHALL set a pending flag on a detected edge; request = pending OR same-cycle edge.
REQ-017 The block SHALL advance state, height and hang counter only on clk cycles with tick high.
REQ-018 On tick in IDLE with request and game_active high, the block SHALL enter ASCEND, clear pending, pulse jump_start that cycle; height unchanged.
REQ-019 In ASCEND on tick, height SHALL become min(height+RISE_STEP, JUMP_HEIGHT), using 9-bit sum; on reaching JUMP_HEIGHT, enter HANG with hang counter 0.
REQ-020 In HANG on tick, counter SHALL increment; when it reaches HANG_TICKS, enter DESCEND.
REQ-021 In DESCEND on tick, height SHALL become max(height-FALL_STEP, 0), no underflow; on reaching 0, enter IDLE.
REQ-022 Edges arriving in ASCEND or HANG SHALL be discarded (pending cleared on each tick outside IDLE/DESCEND).
REQ-023 Holding jump_pressed high SHALL NOT retrigger; a new jump needs a new edge.
REQ-024 game_active low SHALL force IDLE, height 0, pending 0 at next clk, overriding tick and request.
REQ-025 dino_y, airborne and state SHALL update the clk after the tick causing the change.

Reset
REQ-026 On rst, state SHALL be IDLE, height 0, hang counter 0, pending 0, previous-input register 0.
REQ-027 On rst, outputs SHALL be dino_y=GROUND_Y, airborne=0, jump_start=0, state=0; rst mid-jump SHALL abort immediately.

Configuration
REQ-028 With macro JUMP_BUFFER_EN defined, an edge in DESCEND SHALL keep pending set, and the tick landing in IDLE SHALL be followed on the next tick by ASCEND.
REQ-029 Without JUMP_BUFFER_EN, edges in DESCEND SHALL be discarded like ASCEND/HANG.

Verification
REQ-030 Defaults, game_active=1, single edge then ticks -> jump_start once; height 8..64 over 8 ticks, HANG 4 ticks, DESCEND 8 ticks, IDLE after 20 ticks, dino_y back to 200.
REQ-031 Edge and tick in same cycle while IDLE -> ASCEND that tick; dino_y=192 after next tick.
REQ-032 jump_pressed held high through landing -> no second jump_start.
REQ-033 Edge during DESCEND -> with JUMP_BUFFER_EN, jump_start one tick after landing; without, stays IDLE.
REQ-034 rst or game_active low at apex -> next clk state=0, dino_y=200, airborne=0.
REQ-035 JUMP_HEIGHT=60, RISE_STEP=8 -> height saturates at 60 on 8th ASCEND tick, enters HANG.

Source files
------------

// File: rtl/jump_controller.sv
// Dino jump trajectory controller: IDLE -> ASCEND -> HANG -> DESCEND -> IDLE, advancing on game ticks.
// Optional macro JUMP_BUFFER_EN: an edge seen while descending is kept and fires right after landing.
`timescale 1ns/1ps
module jump_controller #(
    parameter int unsigned GROUND_Y    = 200,
    parameter int unsigned JUMP_HEIGHT = 64,
    parameter int unsigned RISE_STEP   = 8,
    parameter int unsigned FALL_STEP   = 8,
    parameter int unsigned HANG_TICKS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       jump_pressed,
    input  logic       game_active,
    output logic [9:0] dino_y,
    output logic       airborne,
    output logic       jump_start,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASCEND  = 2'd1,
        HANG    = 2'd2,
        DESCEND = 2'd3
    } state_t;

    localparam logic [9:0] GROUND_Y10 = 10'(GROUND_Y);
    localparam logic [7:0] APEX       = 8'(JUMP_HEIGHT);
    localparam logic [8:0] RISE9      = 9'(RISE_STEP);
    localparam logic [8:0] FALL9      = 9'(FALL_STEP);
    localparam logic [8:0] HANG9      = 9'(HANG_TICKS);

    state_t     r_state;
    logic [7:0] r_height;
    logic [7:0] r_hang_cnt;
    logic       r_pending;
    logic       r_jump_prev;
    logic [9:0] r_dino_y;

    state_t     w_state_next;
    logic [7:0] w_height_next;
    logic [7:0] w_hang_next;
    logic       w_pending_next;
    logic       w_jump_start;
    logic       w_edge;
    logic       w_request;
    logic [8:0] w_rise_sum;
    logic [8:0] w_hang_inc;
    logic [8:0] w_height9;

    assign w_edge     = jump_pressed & ~r_jump_prev;
    assign w_request  = r_pending | w_edge;
    assign w_height9  = {1'b0, r_height};
    // 9-bit sum so a large RISE_STEP near the apex cannot wrap before the clamp
    assign w_rise_sum = w_height9 + RISE9;
    assign w_hang_inc = {1'b0, r_hang_cnt} + 9'd1;

    always_comb begin
        w_state_next   = r_state;
        w_height_next  = r_height;
        w_hang_next    = r_hang_cnt;
        w_pending_next = r_pending | w_edge;
        w_jump_start   = 1'b0;

        if (!game_active) begin
            w_state_next   = IDLE;
            w_height_next  = 8'd0;
            w_hang_next    = 8'd0;
            w_pending_next = 1'b0;
        end else if (tick) begin
            case (r_state)
                IDLE: begin
                    if (w_request) begin
                        w_state_next   = ASCEND;
                        w_pending_next = 1'b0;
                        w_jump_start   = 1'b1;
                    end
                end
                ASCEND: begin
                    w_pending_next = 1'b0;
                    if (w_rise_sum >= {1'b0, APEX}) begin
                        w_height_next = APEX;
                        w_state_next  = HANG;
                        w_hang_next   = 8'd0;
                    end else begin
                        w_height_next = w_rise_sum[7:0];
                    end
                end
                HANG: begin
                    w_pending_next = 1'b0;
                    w_hang_next    = w_hang_inc[7:0];
                    if (w_hang_inc >= HANG9) begin
                        w_state_next = DESCEND;
                    end
                end
                DESCEND: begin
`ifdef JUMP_BUFFER_EN
                    w_pending_next = r_pending | w_edge;
`else
                    w_pending_next = 1'b0;
`endif
                    if (w_height9 <= FALL9) begin
                        w_height_next = 8'd0;
                        w_state_next  = IDLE;
                    end else begin
                        w_height_next = 8'(w_height9 - FALL9);
                    end
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_height    <= 8'd0;
            r_hang_cnt  <= 8'd0;
            r_pending   <= 1'b0;
            r_jump_prev <= 1'b0;
            r_dino_y    <= GROUND_Y10;
        end else begin
            r_state     <= w_state_next;
            r_height    <= w_height_next;
            r_hang_cnt  <= w_hang_next;
            r_pending   <= w_pending_next;
            r_jump_prev <= jump_pressed;
            r_dino_y    <= GROUND_Y10 - {2'b00, w_height_next};
        end
    end

    assign dino_y     = r_dino_y;
    assign airborne   = (r_state != IDLE);
    assign jump_start = w_jump_start & ~rst;
    assign state      = r_state;

endmodule

// File: tb/tb_jump_controller.sv
// Directed self-checking bench for jump_controller: default build plus a JUMP_HEIGHT=60 instance.
`timescale 1ns/1ps
module tb_jump_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       jump_pressed = 1'b0;
    logic       game_active = 1'b1;
    logic [9:0] dino_y, dino_y2;
    logic       airborne, airborne2;
    logic       jump_start, jump_start2;
    logic [1:0] state, state2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jump_controller dut (
        .clk(clk), .rst(rst), .tick(tick), .jump_pressed(jump_pressed),
        .game_active(game_active), .dino_y(dino_y), .airborne(airborne),
        .jump_start(jump_start), .state(state)
    );

    jump_controller #(.JUMP_HEIGHT(60)) dut60 (
        .clk(clk), .rst(rst), .tick(tick), .jump_pressed(jump_pressed),
        .game_active(game_active), .dino_y(dino_y2), .airborne(airborne2),
        .jump_start(jump_start2), .state(state2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock with the given tick level; returns at posedge+1 with tick low.
    task automatic cycle(input logic t);
        tick = t;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("reset_state", 32'(state), 0);
        check("reset_dino_y", 32'(dino_y), 200);
        check("reset_airborne", 32'(airborne), 0);
        check("reset_jump_start", 32'(jump_start), 0);
        $display("txn reset state=%0d dino_y=%0d", state, dino_y);

        // Edge without tick gets buffered as pending; jump_pressed stays held for the whole jump
        jump_pressed = 1'b1;
        cycle(1'b0);
        check("pending_no_start", 32'(state), 0);
        tick = 1'b1; #1;
        check("start_pulse", 32'(jump_start), 1);
        cycle(1'b1);
        check("start_state", 32'(state), 1);
        check("start_dino_y", 32'(dino_y), 200);
        check("start_airborne", 32'(airborne), 1);
        $display("txn start state=%0d dino_y=%0d", state, dino_y);

        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin
                tick = 1'b1; #1;
                check("no_pulse_ascend", 32'(jump_start), 0);
            end
            cycle(1'b1);
            check("ascend_dino_y", 32'(dino_y), 32'(200 - 8 * i));
            check("ascend_state", 32'(state), (i < 8) ? 1 : 2);
            check("h60_dino_y", 32'(dino_y2), 32'(200 - ((8 * i > 60) ? 60 : 8 * i)));
            check("h60_state", 32'(state2), (8 * i >= 60) ? 2 : 1);
            $display("txn ascend i=%0d state=%0d dino_y=%0d h60_y=%0d", i, state, dino_y, dino_y2);
        end

        for (int j = 1; j <= 4; j++) begin
            cycle(1'b1);
            check("hang_state", 32'(state), (j < 4) ? 2 : 3);
            check("hang_dino_y", 32'(dino_y), 136);
            $display("txn hang j=%0d state=%0d dino_y=%0d", j, state, dino_y);
        end

        for (int k = 1; k <= 8; k++) begin
            cycle(1'b1);
            check("descend_dino_y", 32'(dino_y), 32'(136 + 8 * k));
            check("descend_state", 32'(state), (k < 8) ? 3 : 0);
            $display("txn descend k=%0d state=%0d dino_y=%0d", k, state, dino_y);
        end
        check("landed_airborne", 32'(airborne), 0);

        // Held button must not retrigger after landing
        tick = 1'b1; #1;
        check("held_no_retrigger", 32'(jump_start), 0);
        cycle(1'b1);
        check("held_stays_idle", 32'(state), 0);
        $display("txn held state=%0d jump_start=%0d", state, jump_start);

        // Edge and tick in the same cycle
        jump_pressed = 1'b0;
        cycle(1'b0);
        jump_pressed = 1'b1;
        tick = 1'b1; #1;
        check("same_cycle_pulse", 32'(jump_start), 1);
        cycle(1'b1);
        check("same_cycle_state", 32'(state), 1);
        cycle(1'b1);
        check("same_cycle_dino_y", 32'(dino_y), 192);
        $display("txn same_cycle state=%0d dino_y=%0d", state, dino_y);

        for (int i = 0; i < 7; i++) cycle(1'b1);
        check("apex_state", 32'(state), 2);
        check("apex_dino_y", 32'(dino_y), 136);
        game_active = 1'b0;
        cycle(1'b0);
        check("inactive_state", 32'(state), 0);
        check("inactive_dino_y", 32'(dino_y), 200);
        check("inactive_airborne", 32'(airborne), 0);
        $display("txn game_inactive state=%0d dino_y=%0d", state, dino_y);
        game_active = 1'b1;
        cycle(1'b1);
        check("inactive_no_pending", 32'(state), 0);

        // Reset at apex aborts the jump
        jump_pressed = 1'b0;
        cycle(1'b0);
        jump_pressed = 1'b1;
        cycle(1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b1);
        check("apex2_state", 32'(state), 2);
        rst = 1'b1;
        tick = 1'b1; #1;
        check("rst_no_pulse", 32'(jump_start), 0);
        cycle(1'b1);
        check("rst_state", 32'(state), 0);
        check("rst_dino_y", 32'(dino_y), 200);
        check("rst_airborne", 32'(airborne), 0);
        $display("txn rst_at_apex state=%0d dino_y=%0d", state, dino_y);
        rst = 1'b0;

        // Edge arriving during DESCEND
        jump_pressed = 1'b0;
        cycle(1'b0);
        jump_pressed = 1'b1;
        cycle(1'b1);
        for (int i = 0; i < 15; i++) cycle(1'b1);
        check("desc3_state", 32'(state), 3);
        check("desc3_dino_y", 32'(dino_y), 160);
        jump_pressed = 1'b0;
        cycle(1'b0);
        jump_pressed = 1'b1;
        cycle(1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1);
        check("buffer_landed", 32'(state), 0);
        tick = 1'b1; #1;
`ifdef JUMP_BUFFER_EN
        check("buffer_pulse", 32'(jump_start), 1);
        cycle(1'b1);
        check("buffer_state", 32'(state), 1);
`else
        check("buffer_pulse", 32'(jump_start), 0);
        cycle(1'b1);
        check("buffer_state", 32'(state), 0);
`endif
        $display("txn descend_edge state=%0d dino_y=%0d", state, dino_y);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
